// File: rtl/uart_rx_if.sv
// uart_rx_if: parallel result bus from the UART receiver to the system controller.
// Latency: none, wires only; the producer drives every field from registers.
// Backpressure: none; the consumer must take each one-cycle pulse when it appears.
interface uart_rx_if #(
  parameter int width = 8
);
  logic [width-1:0] P_data;
  logic             Data_valid;
  logic             Parity_error;
  logic             Stop_error;

  modport master (output P_data, Data_valid, Parity_error, Stop_error);
  modport slave  (input  P_data, Data_valid, Parity_error, Stop_error);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample majority vote, optional parity, stop check.
// Latency: result pulse N*Prescale cycles after the start-detect cycle (N = frame bits).
// Backpressure: none; results are one-cycle pulses. Optional macro UART_RX_START_CHECK_EN rejects false starts.
module uart_rx #(
  parameter int width = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Rx_in,
  input  logic [5:0] Prescale,
  input  logic       Parity_EN,
  input  logic       Parity_type,
  uart_rx_if.master  rx_bus
);

  localparam int BCW = (width > 1) ? $clog2(width) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(width - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  logic [5:0]       edge_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic [width-1:0] shift_reg;
  logic [5:0]       pre_q;       // Prescale latched at start detect
  logic             par_en_q;
  logic             par_type_q;
  logic             par_bit;     // voted parity bit of the current frame
  logic [2:0]       samples;     // the three mid-bit samples of the current bit

  logic [5:0] mid;
  logic [5:0] smp_lo;
  logic [5:0] smp_hi;
  logic [5:0] last_edge;
  logic       in_sample;
  logic       bit_end;
  logic       vote;
  logic       par_exp;
  logic       frame_perr;
  logic       frame_serr;

  // Bit-timing decode, majority vote and frame-end error evaluation from registered state.
  always_comb begin
    mid        = {1'b0, pre_q[5:1]};
    smp_lo     = mid - 6'd1;
    smp_hi     = mid + 6'd1;
    last_edge  = pre_q - 6'd1;
    in_sample  = (edge_cnt >= smp_lo) && (edge_cnt <= smp_hi);
    bit_end    = (edge_cnt == last_edge);
    vote       = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
    par_exp    = par_type_q ? ~^shift_reg : ^shift_reg;
    frame_perr = par_en_q && (par_bit != par_exp);
    // In STOP at bit end, the vote is the stop bit itself.
    frame_serr = !vote;
  end

  // Receive FSM: counters, sampling, data capture and registered result pulses.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state               <= IDLE;
      edge_cnt            <= 6'd0;
      bit_cnt             <= '0;
      shift_reg           <= '0;
      pre_q               <= 6'd0;
      par_en_q            <= 1'b0;
      par_type_q          <= 1'b0;
      par_bit             <= 1'b0;
      samples             <= 3'd0;
      rx_bus.P_data       <= '0;
      rx_bus.Data_valid   <= 1'b0;
      rx_bus.Parity_error <= 1'b0;
      rx_bus.Stop_error   <= 1'b0;
    end else begin
      rx_bus.Data_valid   <= 1'b0;
      rx_bus.Parity_error <= 1'b0;
      rx_bus.Stop_error   <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
        if (in_sample) begin
          samples <= {samples[1:0], Rx_in};
        end
      end

      case (state)
        IDLE: begin
          // Start-detect cycle is edge 0 of the start bit, so the next cycle is edge 1.
          if (!Rx_in) begin
            state      <= START;
            edge_cnt   <= 6'd1;
            bit_cnt    <= '0;
            pre_q      <= Prescale;
            par_en_q   <= Parity_EN;
            par_type_q <= Parity_type;
          end
        end

        START: begin
          if (bit_end) begin
            state <= DATA;
          end
`ifdef UART_RX_START_CHECK_EN
          // A start bit that votes high was a glitch: abandon the frame silently.
          if ((edge_cnt == mid + 6'd2) && vote) begin
            state    <= IDLE;
            edge_cnt <= 6'd0;
          end
`endif
        end

        DATA: begin
          if (bit_end) begin
            shift_reg <= {vote, shift_reg[width-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            par_bit <= vote;
            state   <= STOP;
          end
        end

        STOP: begin
          // Back in IDLE on the result cycle so a following start bit is not missed.
          if (bit_end) begin
            state <= IDLE;
            if (!frame_perr && !frame_serr) begin
              rx_bus.P_data     <= shift_reg;
              rx_bus.Data_valid <= 1'b1;
            end else begin
              rx_bus.Parity_error <= frame_perr;
              rx_bus.Stop_error   <= frame_serr;
            end
          end
        end

        default: begin
          state    <= IDLE;
          edge_cnt <= 6'd0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx.
// Latency: expected pulse cycle is computed from the frame length and prescale.
// Backpressure: n/a.
module tb_uart_rx;

  localparam int W = 8;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       Rx_in = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       Parity_EN = 1'b0;
  logic       Parity_type = 1'b0;

  uart_rx_if #(.width(W)) bus ();

  uart_rx #(.width(W)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Rx_in       (Rx_in),
    .Prescale    (Prescale),
    .Parity_EN   (Parity_EN),
    .Parity_type (Parity_type),
    .rx_bus      (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]  cyc;
    logic         dv;
    logic         pe;
    logic         se;
    logic [W-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int unsigned  cyc = 0;
  logic [W-1:0] model_pdata = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (Reset && (bus.Data_valid || bus.Parity_error || bus.Stop_error)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, bus.Data_valid, bus.Parity_error, bus.Stop_error}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_flags", {29'd0, bus.Data_valid, bus.Parity_error, bus.Stop_error},
              {29'd0, e.dv, e.pe, e.se});
        check("p_data", {{(32-W){1'b0}}, bus.P_data}, {{(32-W){1'b0}}, e.data});
      end
    end
  end

  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reference: what a receiver must report for a frame, from the frame's own contents.
  task automatic expect_frame(input logic [W-1:0] d, input bit pe, input bit se, input int unsigned at);
    exp_t e;
    e.cyc = at;
    e.pe  = pe;
    e.se  = se;
    e.dv  = !pe && !se;
    if (e.dv) model_pdata = d;
    e.data = model_pdata;
    exp_q.push_back(e);
  endtask

  // Drives one frame, starting at the current cycle; one optional single-cycle glitch.
  task automatic send_frame(input logic [W-1:0] d, input logic pen, input logic ptype, input int p,
                            input bit bad_par, input bit bad_stop, input int gbit, input int goff,
                            input bit scramble);
    logic bits [0:W+2];
    int   nbits;
    int   ones;
    logic good_par;
    nbits    = W + 2 + int'(pen);
    ones     = $countones(d);
    good_par = ptype ? ((ones % 2) == 0) : ((ones % 2) == 1);
    bits[0]  = 1'b0;
    for (int i = 0; i < W; i++) bits[1+i] = d[i];
    bits[W+1] = pen ? (good_par ^ bad_par) : !bad_stop;
    bits[W+2] = !bad_stop;
    Prescale    = 6'(p);
    Parity_EN   = pen;
    Parity_type = ptype;
    expect_frame(d, pen && bad_par, bad_stop, cyc + 32'(nbits * p));
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < p; k++) begin
        Rx_in = bits[b] ^ ((b == gbit) && (k == goff));
        if (scramble && b == 1 && k == 0) begin
          Prescale    = 6'($urandom);
          Parity_EN   = 1'($urandom);
          Parity_type = 1'($urandom);
        end
        tick();
      end
    end
    Rx_in = 1'b1;
  endtask

  initial begin : stimulus
    int p;
    int nbits;
    int gbit;
    int goff;
    logic pen;
    logic ptype;
    int unsigned c0;

    // Reset state
    repeat (3) tick();
    check("rst_p_data", {24'd0, bus.P_data}, 32'd0);
    check("rst_data_valid", {31'd0, bus.Data_valid}, 32'd0);
    check("rst_parity_error", {31'd0, bus.Parity_error}, 32'd0);
    check("rst_stop_error", {31'd0, bus.Stop_error}, 32'd0);
    Reset = 1'b1;
    repeat (4) tick();

    // 0xA5, P=8, even parity
    send_frame(8'hA5, 1'b1, 1'b0, 8, 0, 0, -1, 0, 0);
    repeat (3) tick();

    // 0x3C then 0xFF back-to-back, P=16, no parity
    send_frame(8'h3C, 1'b0, 1'b0, 16, 0, 0, -1, 0, 0);
    send_frame(8'hFF, 1'b0, 1'b0, 16, 0, 0, -1, 0, 0);
    repeat (2) tick();

    // Odd parity: good then bad parity bit
    send_frame(8'h01, 1'b1, 1'b1, 8, 0, 0, -1, 0, 0);
    send_frame(8'h01, 1'b1, 1'b1, 8, 1, 0, -1, 0, 0);
    repeat (2) tick();
    send_frame(8'h7E, 1'b1, 1'b1, 8, 0, 0, -1, 0, 0);
    send_frame(8'h7E, 1'b1, 1'b1, 8, 1, 0, -1, 0, 0);
    repeat (2) tick();

    // Stop bit held low, then a clean 0x55
    send_frame(8'h55, 1'b0, 1'b0, 8, 0, 1, -1, 0, 0);
    repeat (5) tick();
    send_frame(8'h55, 1'b0, 1'b0, 8, 0, 0, -1, 0, 0);

    // Single-cycle glitch at the centre sample of data bit 3 of 0x00
    send_frame(8'h00, 1'b0, 1'b0, 8, 0, 0, 4, 4, 0);
    repeat (2) tick();

    // Two-cycle low glitch on an idle line
    Prescale = 6'd8; Parity_EN = 1'b1; Parity_type = 1'b0;
    c0 = cyc;
    Rx_in = 1'b0;
    tick(); tick();
    Rx_in = 1'b1;
`ifdef UART_RX_START_CHECK_EN
    // Frame is rejected; receiver must accept a new start at cycle P/2+3.
    repeat (8 / 2 + 3 - 2) tick();
    send_frame(8'h5A, 1'b1, 1'b0, 8, 0, 0, -1, 0, 0);
`else
    // Unvalidated start: an all-ones frame with even parity 1 and good stop.
    expect_frame(8'hFF, 1'b1, 1'b0, c0 + 32'd88);
    repeat (88 - 2) tick();
    send_frame(8'h5A, 1'b1, 1'b0, 8, 0, 0, -1, 0, 0);
`endif
    repeat (3) tick();

    // Reset in the middle of a frame
    Prescale = 6'd8; Parity_EN = 1'b1; Parity_type = 1'b0;
    Rx_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      Rx_in = 1'($urandom);
    end
    Reset = 1'b0;
    Rx_in = 1'b1;
    #1;
    check("midrst_p_data", {24'd0, bus.P_data}, 32'd0);
    check("midrst_data_valid", {31'd0, bus.Data_valid}, 32'd0);
    check("midrst_parity_error", {31'd0, bus.Parity_error}, 32'd0);
    check("midrst_stop_error", {31'd0, bus.Stop_error}, 32'd0);
    model_pdata = '0;
    repeat (3) tick();
    Reset = 1'b1;
    repeat (2) tick();
    send_frame(8'h81, 1'b1, 1'b0, 8, 0, 0, -1, 0, 0);

    // Randomized frames with config changes mid-frame, glitches and errors
    for (int n = 0; n < 20; n++) begin
      p     = 2 * $urandom_range(4, 31);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      nbits = W + 2 + int'(pen);
      if ($urandom_range(0, 1) == 1) begin
        gbit = $urandom_range(0, nbits - 1);
        goff = $urandom_range((gbit == 0) ? 1 : 0, p - 1);
      end else begin
        gbit = -1;
        goff = 0;
      end
      send_frame(8'($urandom), pen, ptype, p,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 gbit, goff, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Drain outstanding expectations with a bounded wait
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
    repeat (4) tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the low-power communication system, the receive-side counterpart of the system's UART transmitter. It oversamples the serial line by a programmable prescale and recovers start, data, optional parity and stop bits using a 3-sample majority vote per bit. It delivers each good byte as a parallel word with a one-cycle `Data_valid` pulse, and flags parity and framing errors. It sits between the external `Rx_in` pin (already synchronised upstream) and the system controller.

## Interface
- `width`, default 8: data bits per frame.
- `CLK`  input  1  receiver clock, running at Prescale × baud.
- `Reset`  input  1  asynchronous, active-low reset.
- `Rx_in`  input  1  serial line; idles high.
- `Prescale`  input  6  oversampling ratio; legal values are even and ≥ 8 (8, 16 and 32 are used).
- `Parity_EN`  input  1  1 = a parity bit follows the data.
- `Parity_type`  input  1  0 = even parity (bit = ^data), 1 = odd parity (bit = ~^data).
- `P_data`  output  width  last received data word, LSB received first.
- `Data_valid`  output  1  one-cycle pulse: `P_data` holds a new, error-free byte.
- `Parity_error`  output  1  one-cycle pulse at frame end when the parity bit mismatches.
- `Stop_error`  output  1  one-cycle pulse at frame end when the stop bit samples 0.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- **Counters.**
  - `edge_cnt` counts 0..Prescale−1 within a bit.
  - `bit_cnt` counts 0..width−1 in DATA.
- **Start detection.** In IDLE, the first cycle with `Rx_in`=0 is edge 0 of the start bit. That cycle sets `edge_cnt`←1 and moves to START. `Prescale`, `Parity_EN` and `Parity_type` are latched in the same cycle; changes to them mid-frame are ignored.
- **Sampling.** `Rx_in` is sampled at edges P/2−1, P/2 and P/2+1, where P is the latched Prescale. The bit value is the majority of the three samples and is resolved by edge P/2+2.
- **Bit end.** At edge P−1, `edge_cnt`←0 and the FSM advances:
  - START → DATA.
  - DATA → DATA until `bit_cnt`=width−1, then → PARITY if `Parity_EN`, else → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- **Data capture.** Data bits shift into an internal shift register, LSB first. Parity is checked against the reduction of that register using the latched `Parity_type`.
- **Frame end.** On the cycle after STOP edge P−1:
  - `P_data` is loaded from the shift register only when there is no parity error and no stop error. Otherwise `P_data` keeps its old value.
  - Exactly one of these happens: `Data_valid` pulses; or `Parity_error` and/or `Stop_error` pulse (both may pulse together).
- **Back-to-back frames.** The FSM is in IDLE on the frame-end cycle, and a low `Rx_in` on that cycle starts the next frame immediately.
- `Rx_in` activity while not in IDLE never restarts framing.

## Timing
- Reset values: `P_data`=0, `Data_valid`=0, `Parity_error`=0, `Stop_error`=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame clears everything immediately. The partial frame is discarded and no pulse is generated.
- Frame length is N = 1 + width + `Parity_EN` + 1 bits. Counting the start-detect cycle as cycle 0, STOP edge P−1 falls at cycle N·P−1. The frame-end pulse occurs at cycle N·P.
- All outputs are registered; nothing is combinational from `Rx_in`.
- A single-sample glitch inside a bit never changes the voted value.

## Configuration
- `UART_RX_START_CHECK_EN` defined:
  - The majority vote of the start bit is evaluated at edge P/2+2.
  - If the vote is 1, the frame is a false start: FSM → IDLE, counters → 0, and no output pulses.
- Not defined:
  - The start bit is not validated; any falling edge commits a full frame.
  - Framing errors then surface only through `Parity_error` and `Stop_error`.

## Test plan
- Prescale=8, `Parity_EN`=1, `Parity_type`=0; send 0xA5 (line: 0,1,0,1,0,0,1,0,1, parity 0, stop 1) → `Data_valid` pulses at cycle 88 with `P_data`=0xA5; no error pulses.
- Prescale=16, `Parity_EN`=0; send 0x3C then 0xFF back-to-back with no idle gap → two `Data_valid` pulses at cycles 160 and 320; `P_data`=0x3C, then 0xFF.
- Prescale=8, `Parity_type`=1; send 0x01 with parity bit 0 (should be 0) → `Data_valid`. Repeat with parity bit 1 → `Parity_error` pulses and `P_data` is unchanged.
- Send 0x55 with the stop bit held 0 → `Stop_error` pulse and no `Data_valid`. Then idle high and send 0x55 correctly → `Data_valid` with `P_data`=0x55.
- With `UART_RX_START_CHECK_EN` defined: 2-cycle low glitch on `Rx_in` → FSM back in IDLE by cycle P/2+3 and no pulses. A 1-cycle glitch on data bit 3 of 0x00 → `P_data`=0x00.
- Assert `Reset` at cycle 40 of a frame, release, then send 0x81 → all outputs read 0 during reset; the next frame yields `P_data`=0x81.
